// File: rtl/pwm_capture_if.sv
// PWM capture bus: the sampled PWM input plus the recovered duty and status flags.
interface pwm_capture_if #(
  parameter int DUTY_W = 7
);
  logic              PWM_IN;
  logic [DUTY_W-1:0] DUTY;
  logic              VALID;
  logic              LOCK;
  logic              STUCK;
  logic              PERIOD_ERR;

  modport master (output PWM_IN, input DUTY, VALID, LOCK, STUCK, PERIOD_ERR);
  modport slave  (input PWM_IN, output DUTY, VALID, LOCK, STUCK, PERIOD_ERR);
endinterface

// File: rtl/pwm_capture.sv
// Times the high phase and period of an incoming PWM stream and recovers its duty value.
// Out-of-tolerance periods are flagged; a missing rising edge forces a stuck indication.
module pwm_capture #(
  parameter int DUTY_W  = 7,
  parameter int PERIOD  = 128,
  parameter int TOL     = 2,
  parameter int TIMEOUT = 256
) (
  input  logic         CLK,
  input  logic         RST_N,
  pwm_capture_if.slave bus
);
  // state    | meaning
  // IDLE     | after reset, waiting for the first rising edge to arm
  // HIGH     | input high, timing the high phase
  // LOW      | input low, high time captured, waiting for the closing rise
  // STUCK_LO | no rising edge for TIMEOUT cycles while low
  // STUCK_HI | input held high for TIMEOUT cycles

  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PER_LO   = CNT_W'((PERIOD > TOL) ? PERIOD - TOL : 0);
  localparam logic [CNT_W-1:0] PER_HI   = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] DUTY_SAT = CNT_W'((1 << DUTY_W) - 1);

  typedef enum logic [2:0] {IDLE, HIGH, LOW, STUCK_LO, STUCK_HI} state_t;

  state_t            state, state_nxt;
  logic              s1, s2, p;
  logic              rise, fall, cnt_max, per_ok;
  logic [CNT_W-1:0]  cnt, hi, hi_nxt;
  logic [DUTY_W-1:0] duty, duty_nxt, duty_clip;
  logic              valid, valid_nxt;
  logic              lock, lock_nxt;
  logic              stuck, stuck_nxt;
  logic              perr, perr_nxt;

  assign rise      = s2 & ~p;
  assign fall      = ~s2 & p;
  assign cnt_max   = (cnt == CNT_MAX);
  assign per_ok    = (cnt >= PER_LO) && (cnt <= PER_HI);
  assign duty_clip = (hi > DUTY_SAT) ? {DUTY_W{1'b1}} : hi[DUTY_W-1:0];

  // cnt restarts at 1 on each rise, so it reads the high time on the fall
  // cycle and the full period on the following rise cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      p   <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= bus.PWM_IN;
      s2 <= s1;
      p  <= s2;
      if (rise)
        cnt <= CNT_W'(1);
      else if (!cnt_max)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // In HIGH the timeout wins over a fall on the same cycle: a high phase of
  // TIMEOUT cycles is already far beyond any legal period.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (rise) state_nxt = HIGH;
      HIGH:     if (cnt_max) state_nxt = STUCK_HI;
                else if (fall) state_nxt = LOW;
      LOW:      if (rise) state_nxt = HIGH;
                else if (cnt_max) state_nxt = STUCK_LO;
      STUCK_LO,
      STUCK_HI: if (rise) state_nxt = HIGH;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hi_nxt    = hi;
    duty_nxt  = duty;
    valid_nxt = 1'b0;
    perr_nxt  = 1'b0;
    lock_nxt  = lock;
    stuck_nxt = stuck;
    case (state)
      HIGH: begin
        if (cnt_max) begin
          duty_nxt  = {DUTY_W{1'b1}};
          valid_nxt = 1'b1;
          stuck_nxt = 1'b1;
          lock_nxt  = 1'b0;
        end else if (fall) begin
          hi_nxt = cnt;
        end
      end
      LOW: begin
        if (rise) begin
          if (per_ok) begin
            duty_nxt  = duty_clip;
            valid_nxt = 1'b1;
            lock_nxt  = 1'b1;
          end else begin
            perr_nxt = 1'b1;
            lock_nxt = 1'b0;
          end
        end else if (cnt_max) begin
          duty_nxt  = '0;
          valid_nxt = 1'b1;
          stuck_nxt = 1'b1;
          lock_nxt  = 1'b0;
        end
      end
      STUCK_LO,
      STUCK_HI: if (rise) stuck_nxt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hi    <= '0;
      duty  <= '0;
      valid <= 1'b0;
      perr  <= 1'b0;
      lock  <= 1'b0;
      stuck <= 1'b0;
    end else begin
      hi    <= hi_nxt;
      duty  <= duty_nxt;
      valid <= valid_nxt;
      perr  <= perr_nxt;
      lock  <= lock_nxt;
      stuck <= stuck_nxt;
    end
  end

  assign bus.DUTY       = duty;
  assign bus.VALID      = valid;
  assign bus.LOCK       = lock;
  assign bus.STUCK      = stuck;
  assign bus.PERIOD_ERR = perr;
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the PWM generator. Samples an incoming PWM waveform, measures its high time and period in CLK cycles, and outputs the recovered 7-bit duty value.
- Used to read back the motor PWM, or an external PWM command, into the same 7-bit duty domain the switches drive.
- Nominal input is the generator's format: period 128 CLK cycles, high time 0..127 cycles.

Parameters:
- DUTY_W, 7: width of DUTY output; recovered high time saturates at 2**DUTY_W-1.
- PERIOD, 128: expected PWM period in CLK cycles.
- TOL, 2: accepted period deviation, ± cycles inclusive.
- TIMEOUT, 256: cycles without a rising edge before stuck detection; must be > PERIOD+TOL; counter width is clog2(TIMEOUT)+1.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RST_N  in  1  asynchronous active-low reset.
- PWM_IN  in  1  asynchronous PWM input.
- DUTY  out  DUTY_W  last accepted duty (high-time cycle count).
- VALID  out  1  one-cycle pulse when DUTY is updated.
- LOCK  out  1  high while the last measured period was within tolerance.
- STUCK  out  1  high while the input has had no rising edge for TIMEOUT cycles.
- PERIOD_ERR  out  1  one-cycle pulse when a full period is measured out of tolerance.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - DUTY=0, VALID=0, LOCK=0, STUCK=0, PERIOD_ERR=0.
  - Synchronizer, edge register and counters cleared; state=IDLE.
  - Reset asserted mid-period discards the partial measurement; the first rising edge after release only arms the block.
- Input path: 2-FF synchronizer (s1, s2) plus a previous-value register p.
  - rise = s2 & ~p; fall = ~s2 & p.
- Counter cnt:
  - On a rise cycle, cnt<=1.
  - Otherwise cnt<=cnt+1, saturating at TIMEOUT.
  - Result: cnt equals the high time on the fall cycle and equals the period on the next rise cycle.
- States:
  - IDLE: wait for rise -> HIGH. No outputs update.
  - HIGH: on fall, hi<=cnt -> LOW. On cnt==TIMEOUT -> STUCK_HI.
  - LOW: on rise:
    - If |cnt-PERIOD|<=TOL: DUTY<=min(hi, 2**DUTY_W-1), VALID=1 for one cycle, LOCK<=1.
    - Else: PERIOD_ERR=1 for one cycle, LOCK<=0, DUTY unchanged.
    - Either way, next state is HIGH and a new period starts on the same edge.
    - On cnt==TIMEOUT -> STUCK_LO.
  - STUCK_LO: entered with DUTY<=0, VALID pulse, STUCK<=1, LOCK<=0. On rise -> HIGH with STUCK<=0 and no VALID until that period completes.
  - STUCK_HI: same as STUCK_LO, but DUTY<=2**DUTY_W-1.
- Latency: VALID is asserted during the 3rd CLK cycle after the posedge that first samples the terminating PWM_IN rising edge high (2 sync stages + 1 output register). DUTY changes on the same edge VALID rises.
- Boundary conditions:
  - Glitch shorter than one CLK period may be missed; no filtering beyond the synchronizer.
  - rise and fall cannot occur in the same cycle.
  - A fall seen in LOW or IDLE is ignored.
  - A high time of 0 is not a pulse. A steady-low input ends in STUCK_LO and DUTY=0.
  - VALID and PERIOD_ERR are never high together.

Test Plan:
- Reset, then PWM_IN high 4 of 128 cycles for 3 periods -> first VALID after 2nd rise, DUTY=4, LOCK=1, VALID exactly once per period, 3 cycles after the sampled rise.
- Duty change 17 -> 0 (held low) -> 127/128: DUTY=17 with VALID; after 256 low cycles STUCK=1, DUTY=0 with one VALID; on the next rise STUCK=0; after 127-high periods DUTY=127.
- Input held high for 300 cycles -> STUCK_HI: DUTY=127, STUCK=1, LOCK=0.
- Period sweep with high time 10: period 126 and 130 -> VALID, DUTY=10. Period 125 and 131 -> PERIOD_ERR pulse, LOCK=0, DUTY keeps its previous value.
- Saturation: PERIOD=200 override, high time 150 -> DUTY=127.
- RST_N pulsed low mid-period at DUTY=50 -> all outputs 0 immediately. No VALID until one full clean period after release, then DUTY=50.
